mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single external memory port.
- Shares the port between the CPU memory interface (instruction/data fetch and MMU PTE walks) and a DMA requester (SD sector loader into RAM).
- CPU has priority; an anti-starvation counter bounds DMA wait, and a timeout watchdog guarantees every accepted transfer completes.
- Sits between the CPU top level and the board memory controller.

---
 rtl/mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single external memory port between the CPU
// memory interface and the DMA sector loader. CPU wins ties unless the DMA
// has already waited DMA_MAX_WAIT consecutive CPU grants. A watchdog aborts
// any transfer that sees no mem_valid within TIMEOUT cycles.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no owner; arbitrate between active requesters
// S_CPU_XFER | CPU fields latched onto mem_*, waiting for mem_valid
// S_DMA_XFER | DMA fields latched onto mem_*, waiting for mem_valid
// S_DONE     | owner valid (and timeout_err on abort) pulses; back to idle
module mem_arbiter #(
    parameter int unsigned DMA_MAX_WAIT = 4,
    parameter int unsigned TIMEOUT      = 1024,
    parameter logic [31:0] ERR_DATA     = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    input  logic [2:0]  i_cpu_size,
    input  logic        i_cpu_rreq,
    input  logic        i_cpu_wreq,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_valid,
    input  logic [31:0] i_dma_addr,
    input  logic [31:0] i_dma_wdata,
    input  logic [2:0]  i_dma_size,
    input  logic        i_dma_rreq,
    input  logic        i_dma_wreq,
    output logic [31:0] o_dma_rdata,
    output logic        o_dma_valid,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [2:0]  o_mem_size,
    output logic        o_mem_rreq,
    output logic        o_mem_wreq,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic [1:0]  o_owner,
    output logic        o_timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CPU_XFER = 2'd1,
        S_DMA_XFER = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [3:0]      STARVE_MAX = 4'(DMA_MAX_WAIT);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_starve;
    logic [WD_W-1:0] r_wd;
    logic [1:0]      r_owner;
    logic [31:0]     r_mem_addr;
    logic [31:0]     r_mem_wdata;
    logic [2:0]      r_mem_size;
    logic            r_mem_rreq;
    logic            r_mem_wreq;
    logic [31:0]     r_cpu_rdata;
    logic [31:0]     r_dma_rdata;
    logic            r_cpu_valid;
    logic            r_dma_valid;
    logic            r_timeout_err;

    logic w_cpu_act;
    logic w_dma_act;
    logic w_grant_cpu;
    logic w_grant_dma;
    logic w_xfer;
    logic w_done_evt;
    logic w_to_evt;
    logic w_finish;

    assign w_cpu_act  = i_cpu_rreq | i_cpu_wreq;
    assign w_dma_act  = i_dma_rreq | i_dma_wreq;
    assign w_xfer     = (r_state == S_CPU_XFER) || (r_state == S_DMA_XFER);
    assign w_done_evt = w_xfer && i_mem_valid;
    assign w_to_evt   = w_xfer && !i_mem_valid && (r_wd == WD_LAST);
    assign w_finish   = w_done_evt || w_to_evt;

    // state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // arbitration and next-state decode
    always_comb begin
        w_state_nxt = r_state;
        w_grant_cpu = 1'b0;
        w_grant_dma = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_dma_act && (!w_cpu_act || r_starve == STARVE_MAX)) begin
                    w_grant_dma = 1'b1;
                    w_state_nxt = S_DMA_XFER;
                end else if (w_cpu_act) begin
                    w_grant_cpu = 1'b1;
                    w_state_nxt = S_CPU_XFER;
                end
            end
            S_CPU_XFER, S_DMA_XFER: begin
                if (w_finish) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // DMA starvation counter, updated only on grant decisions
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_starve <= 4'd0;
        end else if (w_grant_dma) begin
            r_starve <= 4'd0;
        end else if (w_grant_cpu) begin
            if (!w_dma_act)                r_starve <= 4'd0;
            else if (r_starve != STARVE_MAX) r_starve <= r_starve + 4'd1;
        end
    end

    // request latch, memory handshake, watchdog and completion pulses
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_owner       <= 2'b00;
            r_wd          <= '0;
            r_mem_addr    <= 32'h0;
            r_mem_wdata   <= 32'h0;
            r_mem_size    <= 3'b000;
            r_mem_rreq    <= 1'b0;
            r_mem_wreq    <= 1'b0;
            r_cpu_rdata   <= 32'h0;
            r_dma_rdata   <= 32'h0;
            r_cpu_valid   <= 1'b0;
            r_dma_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_cpu_valid   <= 1'b0;
            r_dma_valid   <= 1'b0;
            r_timeout_err <= 1'b0;

            if (w_grant_cpu) begin
                r_owner     <= 2'b01;
                r_wd        <= '0;
                r_mem_addr  <= i_cpu_addr;
                r_mem_wdata <= i_cpu_wdata;
                r_mem_size  <= i_cpu_size;
                r_mem_wreq  <= i_cpu_wreq;
                r_mem_rreq  <= !i_cpu_wreq;
            end else if (w_grant_dma) begin
                r_owner     <= 2'b10;
                r_wd        <= '0;
                r_mem_addr  <= i_dma_addr;
                r_mem_wdata <= i_dma_wdata;
                r_mem_size  <= i_dma_size;
                r_mem_wreq  <= i_dma_wreq;
                r_mem_rreq  <= !i_dma_wreq;
            end

            if (w_xfer) begin
                if (w_finish) begin
                    r_mem_rreq    <= 1'b0;
                    r_mem_wreq    <= 1'b0;
                    r_timeout_err <= w_to_evt;
                    if (r_state == S_CPU_XFER) begin
                        r_cpu_valid <= 1'b1;
                        if (w_to_evt)        r_cpu_rdata <= ERR_DATA;
                        else if (r_mem_rreq) r_cpu_rdata <= i_mem_rdata;
                    end else begin
                        r_dma_valid <= 1'b1;
                        if (w_to_evt)        r_dma_rdata <= ERR_DATA;
                        else if (r_mem_rreq) r_dma_rdata <= i_mem_rdata;
                    end
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
            end

            if (r_state == S_DONE) r_owner <= 2'b00;
        end
    end

    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_mem_size    = r_mem_size;
    assign o_mem_rreq    = r_mem_rreq;
    assign o_mem_wreq    = r_mem_wreq;
    assign o_cpu_rdata   = r_cpu_rdata;
    assign o_dma_rdata   = r_dma_rdata;
    assign o_cpu_valid   = r_cpu_valid;
    assign o_dma_valid   = r_dma_valid;
    assign o_owner       = r_owner;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a latency-programmable
// memory responder.
module tb_mem_arbiter;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
    logic [2:0]  cpu_size = '0, dma_size = '0;
    logic        cpu_rreq = 1'b0, cpu_wreq = 1'b0, dma_rreq = 1'b0, dma_wreq = 1'b0;
    logic [31:0] o_cpu_rdata, o_dma_rdata, o_mem_addr, o_mem_wdata;
    logic        o_cpu_valid, o_dma_valid, o_mem_rreq, o_mem_wreq, o_timeout_err;
    logic [2:0]  o_mem_size;
    logic [1:0]  o_owner;
    logic [31:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;

    int          mem_lat = 3;
    bit          mem_xor = 1'b0;
    logic [31:0] mem_fix = '0;
    int          mcnt = 0;

    typedef struct {
        logic [1:0]  own;
        logic [31:0] rd;
        logic        to;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_dma_rd = '0;

    mem_arbiter #(.DMA_MAX_WAIT(4), .TIMEOUT(16), .ERR_DATA(32'h0000_0000)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata), .i_cpu_size(cpu_size),
        .i_cpu_rreq(cpu_rreq), .i_cpu_wreq(cpu_wreq),
        .o_cpu_rdata(o_cpu_rdata), .o_cpu_valid(o_cpu_valid),
        .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata), .i_dma_size(dma_size),
        .i_dma_rreq(dma_rreq), .i_dma_wreq(dma_wreq),
        .o_dma_rdata(o_dma_rdata), .o_dma_valid(o_dma_valid),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_size(o_mem_size),
        .o_mem_rreq(o_mem_rreq), .o_mem_wreq(o_mem_wreq),
        .i_mem_rdata(mem_rdata), .i_mem_valid(mem_valid),
        .o_owner(o_owner), .o_timeout_err(o_timeout_err)
    );

    always #5 clk = ~clk;

    // memory responder: mem_valid in the mem_lat-th cycle of a request, never if negative
    always @(posedge clk) begin
        #1;
        if (rst) begin
            mem_valid = 1'b0;
            mcnt = 0;
        end else if (mem_valid) begin
            mem_valid = 1'b0;
            mcnt = 0;
        end else if ((o_mem_rreq || o_mem_wreq) && mem_lat >= 0) begin
            if (mcnt == mem_lat) begin
                mem_valid = 1'b1;
                mem_rdata = mem_xor ? (o_mem_addr ^ K) : mem_fix;
            end else begin
                mcnt++;
            end
        end else begin
            mcnt = 0;
        end
    end

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (o_cpu_valid || o_dma_valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({o_owner, o_mem_rreq, o_mem_wreq} !== 4'b0) begin
            n_fail++; $display("FAIL reset_req owner=%b rreq=%b wreq=%b expected 0", o_owner, o_mem_rreq, o_mem_wreq);
        end
        n_tests++;
        if ({o_cpu_valid, o_dma_valid, o_timeout_err} !== 3'b0) begin
            n_fail++; $display("FAIL reset_pulse cv=%b dv=%b to=%b expected 0", o_cpu_valid, o_dma_valid, o_timeout_err);
        end
        n_tests++;
        if ({o_mem_addr, o_cpu_rdata, o_dma_rdata} !== 96'h0) begin
            n_fail++; $display("FAIL reset_data addr=%h crd=%h drd=%h expected 0", o_mem_addr, o_cpu_rdata, o_dma_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cpu_read();
        exp_t e;
        int   rq_cycles = 0;
        bit   dv_seen = 1'b0, prev_mv = 1'b0, mv_before = 1'b0, ok = 1'b0;
        mem_lat = 3; mem_xor = 1'b0; mem_fix = 32'hCAFE_BABE;
        exp_q.push_back('{own: 2'b01, rd: 32'hCAFE_BABE, to: 1'b0});
        cpu_addr = 32'h0000_1000; cpu_rreq = 1'b1;
        @(negedge clk);
        n_tests++;
        if (o_mem_rreq !== 1'b1 || o_mem_wreq !== 1'b0 || o_owner !== 2'b01) begin
            n_fail++; $display("FAIL cpu_rd_grant rreq=%b wreq=%b owner=%b expected 1 0 01", o_mem_rreq, o_mem_wreq, o_owner);
        end
        n_tests++;
        if (o_mem_addr !== 32'h0000_1000) begin
            n_fail++; $display("FAIL cpu_rd_addr got %h expected 00001000", o_mem_addr);
        end
        for (int i = 0; i < 30 && !ok; i++) begin
            if (o_mem_rreq) rq_cycles++;
            if (o_dma_valid) dv_seen = 1'b1;
            prev_mv = mem_valid;
            @(negedge clk);
            if (o_cpu_valid) begin ok = 1'b1; mv_before = prev_mv; end
        end
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL cpu_rd_valid got none expected cpu_valid within 30 cycles");
        end else begin
            e = exp_q.pop_front();
            if (o_cpu_rdata !== e.rd || o_owner !== e.own || o_timeout_err !== e.to) begin
                n_fail++; $display("FAIL cpu_rd_data rdata=%h owner=%b to=%b expected %h %b %b", o_cpu_rdata, o_owner, o_timeout_err, e.rd, e.own, e.to);
            end
            n_tests++;
            if (!mv_before || rq_cycles != 4) begin
                n_fail++; $display("FAIL cpu_rd_timing mv_prev=%b rreq_cycles=%0d expected 1 4", mv_before, rq_cycles);
            end
        end
        cpu_rreq = 1'b0;
        @(negedge clk);
        n_tests++;
        if (o_owner !== 2'b00 || o_cpu_valid !== 1'b0 || dv_seen) begin
            n_fail++; $display("FAIL cpu_rd_end owner=%b cv=%b dma_valid_seen=%b expected 00 0 0", o_owner, o_cpu_valid, dv_seen);
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        bit   ok;
        bit   stop = 1'b0;
        mem_lat = 1; mem_xor = 1'b1;
        cpu_addr = 32'h0000_0A00; dma_addr = 32'h0000_0B00;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) exp_q.push_back('{own: 2'b10, rd: 32'h0000_0B00 ^ K, to: 1'b0});
            else            exp_q.push_back('{own: 2'b01, rd: 32'h0000_0A00 ^ K, to: 1'b0});
        end
        cpu_rreq = 1'b1; dma_rreq = 1'b1;
        for (int k = 0; k < 10 && !stop; k++) begin
            wait_valid(20, ok);
            n_tests++;
            if (!ok) begin
                n_fail++; $display("FAIL sim_valid[%0d] got none expected a valid pulse", k);
                stop = 1'b1;
            end else begin
                e = exp_q.pop_front();
                if (o_owner !== e.own || {o_dma_valid, o_cpu_valid} !== e.own) begin
                    n_fail++; $display("FAIL sim_owner[%0d] owner=%b valids=%b%b expected %b", k, o_owner, o_dma_valid, o_cpu_valid, e.own);
                end
                n_tests++;
                if ((e.own == 2'b01 ? o_cpu_rdata : o_dma_rdata) !== e.rd) begin
                    n_fail++; $display("FAIL sim_rdata[%0d] cpu=%h dma=%h expected %h", k, o_cpu_rdata, o_dma_rdata, e.rd);
                end
                if (e.own == 2'b10) exp_dma_rd = e.rd;
                if (k == 9) begin
                    cpu_rreq = 1'b0; dma_rreq = 1'b0;
                end else if (e.own == 2'b01) begin
                    cpu_rreq = 1'b0; @(negedge clk); cpu_rreq = 1'b1;
                end else begin
                    dma_rreq = 1'b0; @(negedge clk); dma_rreq = 1'b1;
                end
            end
        end
        cpu_rreq = 1'b0; dma_rreq = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_prec();
        bit ok;
        mem_lat = 2; mem_xor = 1'b1;
        dma_addr = 32'h0000_2000; dma_wdata = 32'h1234_5678; dma_size = 3'b010;
        dma_rreq = 1'b1; dma_wreq = 1'b1;
        @(negedge clk);
        n_tests++;
        if (o_mem_wreq !== 1'b1 || o_mem_rreq !== 1'b0 || o_owner !== 2'b10) begin
            n_fail++; $display("FAIL wr_prec_req wreq=%b rreq=%b owner=%b expected 1 0 10", o_mem_wreq, o_mem_rreq, o_owner);
        end
        n_tests++;
        if (o_mem_wdata !== 32'h1234_5678 || o_mem_size !== 3'b010 || o_mem_addr !== 32'h0000_2000) begin
            n_fail++; $display("FAIL wr_prec_fields wdata=%h size=%b addr=%h expected 12345678 010 00002000", o_mem_wdata, o_mem_size, o_mem_addr);
        end
        wait_valid(20, ok);
        n_tests++;
        if (!ok || o_dma_valid !== 1'b1 || o_dma_rdata !== exp_dma_rd) begin
            n_fail++; $display("FAIL wr_prec_done ok=%b dv=%b drd=%h expected 1 1 %h", ok, o_dma_valid, o_dma_rdata, exp_dma_rd);
        end
        dma_rreq = 1'b0; dma_wreq = 1'b0; dma_size = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int rq_cycles = 0;
        bit ok = 1'b0;
        mem_lat = -1;
        exp_q.push_back('{own: 2'b01, rd: 32'h0000_0000, to: 1'b1});
        cpu_addr = 32'h0000_3000; cpu_rreq = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (o_mem_rreq) rq_cycles++;
            if (o_cpu_valid || o_timeout_err) ok = 1'b1;
        end
        n_tests++;
        if (rq_cycles != 16) begin
            n_fail++; $display("FAIL to_rreq_cycles got %0d expected 16", rq_cycles);
        end
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL to_pulse got none expected timeout within 40 cycles");
        end else begin
            exp_t e = exp_q.pop_front();
            if (o_cpu_valid !== 1'b1 || o_timeout_err !== e.to || o_cpu_rdata !== e.rd || o_owner !== e.own) begin
                n_fail++; $display("FAIL to_result cv=%b to=%b rd=%h own=%b expected 1 %b %h %b", o_cpu_valid, o_timeout_err, o_cpu_rdata, o_owner, e.to, e.rd, e.own);
            end
        end
        cpu_rreq = 1'b0;
        @(negedge clk);
        n_tests++;
        if (o_timeout_err !== 1'b0 || o_cpu_valid !== 1'b0) begin
            n_fail++; $display("FAIL to_single_pulse to=%b cv=%b expected 0 0", o_timeout_err, o_cpu_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_input_change();
        bit ok = 1'b0;
        bit moved = 1'b0;
        mem_lat = 4; mem_xor = 1'b0; mem_fix = 32'h0BAD_F00D;
        exp_q.push_back('{own: 2'b01, rd: 32'h0BAD_F00D, to: 1'b0});
        cpu_addr = 32'h0000_0100; cpu_rreq = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (o_mem_addr !== 32'h0000_0100) moved = 1'b1;
            cpu_addr = 32'h0000_0200;
            if (o_cpu_valid) ok = 1'b1;
        end
        n_tests++;
        if (!ok || moved) begin
            n_fail++; $display("FAIL in_change_addr ok=%b addr=%h moved=%b expected 1 00000100 0", ok, o_mem_addr, moved);
        end
        n_tests++;
        if (ok) begin
            exp_t e = exp_q.pop_front();
            if (o_cpu_rdata !== e.rd) begin
                n_fail++; $display("FAIL in_change_rdata got %h expected %h", o_cpu_rdata, e.rd);
            end
        end else begin
            n_fail++; $display("FAIL in_change_rdata got no completion expected %h", 32'h0BAD_F00D);
            exp_q.delete();
        end
        cpu_rreq = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        mem_lat = -1;
        dma_addr = 32'h0000_0400; dma_rreq = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (o_mem_rreq !== 1'b1 || o_owner !== 2'b10) begin
            n_fail++; $display("FAIL rst_mid_pre rreq=%b owner=%b expected 1 10", o_mem_rreq, o_owner);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({o_mem_rreq, o_mem_wreq, o_owner, o_cpu_valid, o_dma_valid, o_timeout_err} !== 7'b0) begin
            n_fail++; $display("FAIL rst_mid_clear rreq=%b wreq=%b owner=%b cv=%b dv=%b to=%b expected 0",
                               o_mem_rreq, o_mem_wreq, o_owner, o_cpu_valid, o_dma_valid, o_timeout_err);
        end
        @(negedge clk);
        rst = 1'b0; dma_rreq = 1'b0;
        @(negedge clk);
        mem_lat = 2; mem_xor = 1'b1;
        exp_q.push_back('{own: 2'b01, rd: 32'h0000_0500 ^ K, to: 1'b0});
        cpu_addr = 32'h0000_0500; cpu_rreq = 1'b1;
        @(negedge clk);
        n_tests++;
        if (o_mem_rreq !== 1'b1 || o_owner !== 2'b01 || o_mem_addr !== 32'h0000_0500) begin
            n_fail++; $display("FAIL rst_mid_regrant rreq=%b owner=%b addr=%h expected 1 01 00000500", o_mem_rreq, o_owner, o_mem_addr);
        end
        wait_valid(20, ok);
        n_tests++;
        if (!ok || o_cpu_valid !== 1'b1 || o_dma_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_done ok=%b cv=%b dv=%b expected 1 1 0", ok, o_cpu_valid, o_dma_valid);
            exp_q.delete();
        end else begin
            exp_t e = exp_q.pop_front();
            n_tests++;
            if (o_cpu_rdata !== e.rd) begin
                n_fail++; $display("FAIL rst_mid_rdata got %h expected %h", o_cpu_rdata, e.rd);
            end
        end
        cpu_rreq = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_simultaneous();
        test_write_prec();
        test_timeout();
        test_input_change();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
